alu_result_fifo: RTL
====================

Name: alu_result_fifo

Overview:
- Downstream stage of the 8-bit ALU: captures each combinational ALU result (16-bit value, carry-out, opcode) with a valid/ready handshake.
- Derives status flags at capture time and buffers result and flags in a small FIFO.
- Presents buffered entries to the consumer (register-file writeback or bus bridge) in order, with backpressure.
- Decouples ALU issue rate from consumer acceptance rate.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  ALU result present this cycle.
- in_ready  out  1  stage can accept an entry.
- in_result  in  16  ALU output value.
- in_cout  in  1  ALU carry-out.
- in_opcode  in  3  opcode that produced the result.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head.
- out_result  out  16  head result.
- out_opcode  out  3  head opcode.
- out_flags  out  4  head flags {W,B,C,Z} (bit3..bit0).
- count  out  CW  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset state:
  - rst_n low at a rising edge clears write pointer, read pointer and count.
  - After reset: count=0, empty=1, full=0, out_valid=0, in_ready=1.
  - Storage contents are not reset.
  - out_result, out_opcode and out_flags are don't-care while out_valid=0; the bench must not check them then.
- Reset mid-operation: all buffered entries are discarded. Any push or pop in the reset cycle has no effect.
- Handshakes:
  - in_ready = !full. This is combinational from registered state only, with no dependence on out_ready.
  - Push occurs when in_valid && in_ready.
  - out_valid = !empty. Pop occurs when out_valid && out_ready.
- Latency and ordering:
  - An entry pushed at edge N is visible at the outputs after edge N; minimum 1-cycle latency.
  - There is no same-cycle bypass when empty.
  - Outputs are read combinationally from storage at the read pointer.
- Simultaneous push and pop:
  - When neither empty nor full: both happen and count is unchanged.
  - When empty: only the push happens, since out_valid=0.
  - When full: only the pop happens, since in_ready=0. count becomes DEPTH-1 and in_ready rises the next cycle.
- Pointers: log2(DEPTH) bits each; they wrap naturally from DEPTH-1 to 0.
- Payload stability: while out_valid=1 and out_ready=0, the outputs hold stable.
- Flags, computed from the input payload at push time and stored with the entry:
  - Z = (in_result == 16'h0000), for all opcodes.
  - C = in_cout when in_opcode == ADD (3'b000), else 0.
  - B = in_result[15] when in_opcode == SUB (3'b001), i.e. a < b borrow in 16-bit wrap; else 0.
  - W = (in_result[15:8] != 0) when in_opcode is MUL (3'b010) or LSHIFT (3'b011), i.e. the result exceeds 8 bits; else 0.
- Illegal input: an in_valid assertion while full is not an error. The producer holds its payload until in_ready.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants ADD, SUB, MUL, LSHIFT, RSHIFT, AND_OP, OR_OP, XOR_OP.
  - Flag index constants FLG_Z=0, FLG_C=1, FLG_B=2, FLG_W=3.
  - Typedef alu_entry_t holding {result[15:0], opcode[2:0], flags[3:0]}.
  - These are reused by the ALU and by downstream writeback.
- Sub-module alu_flag_gen: purely combinational; takes result, cout and opcode; produces flags[3:0].
- The FIFO control (pointers, count, handshake) stays in the top module.

Test Plan:
- Reset then idle → count=0, empty=1, in_ready=1, out_valid=0. Hold rst_n low across two edges with in_valid=1 → still empty.
- Push ADD result 16'h0100, cout=1 → next cycle out_valid=1, out_result=16'h0100, out_flags=4'b0010 (C only; W=0 because opcode is ADD).
- Push SUB result 16'hFFFE (3-5), then MUL result 16'h00FF*... = 16'hFE01 (0xFF*0xFF), then XOR result 16'h0000 → pop in order:
  - SUB: flags 4'b0100.
  - MUL: flags 4'b1000.
  - XOR: flags 4'b0001.
- With out_ready=0, push 4 entries → full=1, in_ready=0, count=4. A 5th in_valid is not accepted. Assert out_ready and in_valid together → pop and no push that cycle, count=3, then the push is accepted next cycle.
- At count=2, push and pop simultaneously for 10 cycles with incrementing results → count stays 2, outputs in exact push order across pointer wrap.
- Fill to 3 entries, pulse rst_n low for one edge → count=0, out_valid=0. A subsequent push/pop of 16'h1234 (OR) returns 16'h1234 with flags 4'b0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, status-flag bit positions and the buffered result entry.
// Used by the ALU, this result FIFO and downstream writeback.
package alu_pkg;

    localparam logic [2:0] ADD    = 3'b000;
    localparam logic [2:0] SUB    = 3'b001;
    localparam logic [2:0] MUL    = 3'b010;
    localparam logic [2:0] LSHIFT = 3'b011;
    localparam logic [2:0] RSHIFT = 3'b100;
    localparam logic [2:0] AND_OP = 3'b101;
    localparam logic [2:0] OR_OP  = 3'b110;
    localparam logic [2:0] XOR_OP = 3'b111;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_B = 2;
    localparam int FLG_W = 3;

    typedef struct packed {
        logic [15:0] result;
        logic [2:0]  opcode;
        logic [3:0]  flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// Producer and consumer handshake bundle around the ALU result FIFO.
// The slave modport is the FIFO itself; the master modport is the ALU/consumer side.
interface alu_result_fifo_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic        in_cout;
    logic [2:0]  in_opcode;

    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_opcode;
    logic [3:0]  out_flags;

    modport slave (
        input  in_valid, in_result, in_cout, in_opcode, out_ready,
        output in_ready, out_valid, out_result, out_opcode, out_flags
    );

    modport master (
        output in_valid, in_result, in_cout, in_opcode, out_ready,
        input  in_ready, out_valid, out_result, out_opcode, out_flags
    );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational status-flag derivation from a raw ALU result.
// Flags are only meaningful for the opcodes that can set them; all others read 0.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [15:0] result,
    input  logic        cout,
    input  logic [2:0]  opcode,
    output logic [3:0]  flags
);

    always_comb begin
        flags        = '0;
        flags[FLG_Z] = (result == 16'h0000);
        flags[FLG_C] = (opcode == ADD) ? cout : 1'b0;
        // Subtraction wraps in 16 bits, so a set MSB means a < b.
        flags[FLG_B] = (opcode == SUB) ? result[15] : 1'b0;
        flags[FLG_W] = ((opcode == MUL) || (opcode == LSHIFT)) ? (result[15:8] != 8'h00) : 1'b0;
    end

endmodule

// File: rtl/alu_result_fifo.sv
// ALU result capture stage: stores result, opcode and derived flags in a small FIFO
// and hands them to the consumer in order with valid/ready backpressure.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_result_fifo_if.slave    bus,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty
);

    localparam int AW = $clog2(DEPTH);

    alu_entry_t       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [3:0]       in_flags;
    logic             push;
    logic             pop;
    alu_entry_t       head;

    alu_flag_gen u_flag_gen (
        .result (bus.in_result),
        .cout   (bus.in_cout),
        .opcode (bus.in_opcode),
        .flags  (in_flags)
    );

    assign full          = (count == CW'(DEPTH));
    assign empty         = (count == '0);
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    assign head           = mem[rd_ptr];
    assign bus.out_result = head.result;
    assign bus.out_opcode = head.opcode;
    assign bus.out_flags  = head.flags;

    // Storage has no reset; a push in a reset cycle is still suppressed so it leaves no trace.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= '{result: bus.in_result, opcode: bus.in_opcode, flags: in_flags};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
